spi_regif: RTL and testbench

Parametrised SPI register-interface target: the next-generation front end between the external SPI host and the chip's register file. SPI mode 0 signals are sampled in the `clk_i` domain and decoded into command frames: a R/W bit plus an address, followed by one or more data words. The block issues single-cycle write strobes and read strobes to the register file, with optional burst auto-increment. Address and data widths are parameters; the default 7/8 matches the current register map.

---
 rtl/spi_regif.sv | 173 +++++++++++++++++
 tb/tb_spi_regif.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_regif.sv
// SPI mode-0 target that decodes R/W + address command frames into register-file strobes.
// Define SPI_REGIF_BURST_EN for multi-word frames with address auto-increment and read prefetch.
module spi_regif #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sclk_i,
  input  logic              cs_i,
  input  logic              mosi_i,
  output logic              miso_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic              reg_we_o,
  output logic              reg_re_o
);

  localparam int SH_W  = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int CNT_W = $clog2(SH_W + 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
`ifdef SPI_REGIF_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_HOLD} state_e;

  state_e state_q, state_d;

  // [0],[1] synchroniser, [2] edge-detect history
  logic [2:0] sclk_q, cs_q;
  logic [1:0] mosi_q;
  logic [1:0] settle_q;
  logic       armed_q;

  logic [CNT_W-1:0]  bit_cnt_q;
  logic [SH_W-2:0]   sh_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] tx_q;
  logic              miso_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] raddr_q;
  logic              we_q, re_q;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic clr, cmd_shift, cmd_done, dat_shift, word_done, tx_shift, do_write, do_fetch;
  logic [SH_W-1:0]   shift_nx;
  logic [ADDR_W-1:0] cmd_addr, next_addr, fetch_addr;
  logic              cmd_wr;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  // After reset a frame only starts once cs has been seen high through a settled synchroniser.
  assign cs_fall   = armed_q & ~cs_q[1] & cs_q[2];

  assign shift_nx   = {sh_q, mosi_q[1]};
  assign cmd_addr   = shift_nx[ADDR_W-1:0];
  assign cmd_wr     = shift_nx[ADDR_W];
  assign next_addr  = addr_q + ADDR_W'(1);
  assign fetch_addr = cmd_done ? cmd_addr : next_addr;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cs_fall) state_d = S_CMD;
      S_CMD: begin
        if (cs_rise)       state_d = S_IDLE;
        else if (cmd_done) state_d = S_DATA;
      end
      S_DATA: begin
        if (cs_rise)                state_d = S_IDLE;
        else if (word_done && !BURST) state_d = S_HOLD;
      end
      S_HOLD: if (cs_rise) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    clr       = 1'b0;
    cmd_shift = 1'b0;
    dat_shift = 1'b0;
    tx_shift  = 1'b0;
    unique case (state_q)
      S_IDLE: clr = cs_fall;
      S_CMD:  cmd_shift = sclk_rise & ~cs_rise;
      S_DATA: begin
        dat_shift = sclk_rise & ~cs_rise;
        tx_shift  = sclk_fall & ~cs_rise & ~wr_q;
      end
      default: ;
    endcase
    cmd_done  = cmd_shift & (bit_cnt_q == CMD_LAST);
    word_done = dat_shift & (bit_cnt_q == DATA_LAST);
    do_write  = word_done & wr_q;
    do_fetch  = (cmd_done & ~cmd_wr) | (BURST & word_done & ~wr_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sclk_q    <= 3'b000;
      cs_q      <= 3'b111;
      mosi_q    <= 2'b00;
      settle_q  <= '0;
      armed_q   <= 1'b0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      wdata_q   <= '0;
      raddr_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      cs_q   <= {cs_q[1:0], cs_i};
      mosi_q <= {mosi_q[0], mosi_i};
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd3 && cs_q[1]) armed_q <= 1'b1;

      if (clr) begin
        bit_cnt_q <= '0;
        sh_q      <= '0;
      end else if (cmd_shift || dat_shift) begin
        sh_q      <= shift_nx[SH_W-2:0];
        bit_cnt_q <= (cmd_done || word_done) ? '0 : bit_cnt_q + CNT_W'(1);
      end

      if (cmd_done) begin
        addr_q <= cmd_addr;
        wr_q   <= cmd_wr;
      end else if (word_done) begin
        addr_q <= next_addr;
      end

      we_q <= do_write;
      re_q <= do_fetch;
      if (do_write) begin
        wdata_q <= shift_nx[DATA_W-1:0];
        raddr_q <= addr_q;
      end else if (do_fetch) begin
        raddr_q <= fetch_addr;
      end

      // Read data is captured while the read strobe and its address are on the bus.
      if (re_q)          tx_q <= reg_rdata_i;
      else if (tx_shift) tx_q <= tx_q << 1;

      if (cs_rise)       miso_q <= 1'b0;
      else if (tx_shift) miso_q <= tx_q[DATA_W-1];
    end
  end

  assign miso_o      = miso_q;
  assign reg_wdata_o = wdata_q;
  assign reg_addr_o  = raddr_q;
  assign reg_we_o    = we_q;
  assign reg_re_o    = re_q;

endmodule

// File: tb/tb_spi_regif.sv
// Directed bench for spi_regif: SPI host driver plus a strobe logger; burst cases
// run when SPI_REGIF_BURST_EN is defined, single-word cases otherwise.
module tb_spi_regif;

  localparam int HP = 6;

  logic       clk = 1'b0;
  logic       rst_n, sclk, cs, mosi;
  logic       miso, we, re;
  logic [7:0] rdata, wdata;
  logic [6:0] addr;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int both_cnt = 0;

  logic [6:0] wa_q[$];
  logic [7:0] wd_q[$];
  logic [6:0] ra_q[$];

  always #10 clk = ~clk;

  // register file model: read data = address + 0x40
  assign rdata = {1'b0, addr} + 8'h40;

  spi_regif #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sclk_i(sclk), .cs_i(cs), .mosi_i(mosi),
    .miso_o(miso), .reg_rdata_i(rdata), .reg_wdata_o(wdata),
    .reg_addr_o(addr), .reg_we_o(we), .reg_re_o(re)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (we) begin
        wa_q.push_back(addr);
        wd_q.push_back(wdata);
      end
      if (re) ra_q.push_back(addr);
      if (we && re) both_cnt++;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    ra_q.delete();
  endtask

  task automatic cs_begin();
    cs = 1'b0;
    clks(8);
  endtask

  task automatic cs_end();
    clks(HP);
    cs = 1'b1;
    clks(12);
  endtask

  task automatic spi_bits(input logic [15:0] val, input int n, output logic [15:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = val[i];
      clks(HP);
      rx = {rx[14:0], miso};
      sclk = 1'b1;
      clks(HP);
      sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    chk_cnt++; if (miso !== 1'b0)  $display("FAIL rst_miso: got %b want 0", miso);   else pass_cnt++;
    chk_cnt++; if (wdata !== 8'h0) $display("FAIL rst_wdata: got %h want 00", wdata); else pass_cnt++;
    chk_cnt++; if (addr !== 7'h0)  $display("FAIL rst_addr: got %h want 00", addr);   else pass_cnt++;
    chk_cnt++; if (we !== 1'b0)    $display("FAIL rst_we: got %b want 0", we);        else pass_cnt++;
    chk_cnt++; if (re !== 1'b0)    $display("FAIL rst_re: got %b want 0", re);        else pass_cnt++;
  endtask

  task automatic test_single_write();
    logic [15:0] rx;
    clear_log();
    cs_begin();
    spi_bits(16'h0085, 8, rx);
    spi_bits(16'h00A5, 8, rx);
    cs_end();
    chk_cnt++; if (wa_q.size() !== 1) $display("FAIL wr_count: got %0d want 1", wa_q.size()); else pass_cnt++;
    chk_cnt++; if (wa_q[0] !== 7'h05) $display("FAIL wr_addr: got %h want 05", wa_q[0]);     else pass_cnt++;
    chk_cnt++; if (wd_q[0] !== 8'hA5) $display("FAIL wr_data: got %h want a5", wd_q[0]);     else pass_cnt++;
    chk_cnt++; if (ra_q.size() !== 0) $display("FAIL wr_re_count: got %0d want 0", ra_q.size()); else pass_cnt++;
  endtask

  task automatic test_single_read();
    logic [15:0] rx;
    clear_log();
    cs_begin();
    spi_bits(16'h0003, 8, rx);
    spi_bits(16'h0000, 8, rx);
    cs_end();
    chk_cnt++; if (rx[7:0] !== 8'h43) $display("FAIL rd_miso: got %h want 43", rx[7:0]);     else pass_cnt++;
    chk_cnt++; if (ra_q.size() < 1)   $display("FAIL rd_re_count: got %0d want >=1", ra_q.size()); else pass_cnt++;
    chk_cnt++; if (ra_q[0] !== 7'h03) $display("FAIL rd_re_addr: got %h want 03", ra_q[0]);  else pass_cnt++;
    chk_cnt++; if (wa_q.size() !== 0) $display("FAIL rd_we_count: got %0d want 0", wa_q.size()); else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [15:0] rx;
    clear_log();
    cs_begin();
    spi_bits(16'h0081, 8, rx);
    spi_bits(16'h001F, 5, rx);
    cs_end();
    chk_cnt++; if (wa_q.size() !== 0) $display("FAIL abort_no_we: got %0d want 0", wa_q.size()); else pass_cnt++;
    cs_begin();
    spi_bits(16'h0082, 8, rx);
    spi_bits(16'h005A, 8, rx);
    cs_end();
    chk_cnt++; if (wa_q.size() !== 1) $display("FAIL abort_next_count: got %0d want 1", wa_q.size()); else pass_cnt++;
    chk_cnt++; if (wa_q[0] !== 7'h02) $display("FAIL abort_next_addr: got %h want 02", wa_q[0]); else pass_cnt++;
    chk_cnt++; if (wd_q[0] !== 8'h5A) $display("FAIL abort_next_data: got %h want 5a", wd_q[0]); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    logic [15:0] rx;
    clear_log();
    cs_begin();
    spi_bits(16'h0008, 4, rx);
    rst_n = 1'b0;
    clks(3);
    rst_n = 1'b1;
    spi_bits(16'h0005, 4, rx);
    spi_bits(16'h00A5, 8, rx);
    cs_end();
    chk_cnt++; if (wa_q.size() + ra_q.size() !== 0)
      $display("FAIL midrst_no_strobe: got %0d want 0", wa_q.size() + ra_q.size()); else pass_cnt++;
    cs_begin();
    spi_bits(16'h0085, 8, rx);
    spi_bits(16'h0011, 8, rx);
    cs_end();
    chk_cnt++; if (wa_q.size() !== 1) $display("FAIL midrst_next_count: got %0d want 1", wa_q.size()); else pass_cnt++;
    chk_cnt++; if (wa_q[0] !== 7'h05) $display("FAIL midrst_next_addr: got %h want 05", wa_q[0]); else pass_cnt++;
    chk_cnt++; if (wd_q[0] !== 8'h11) $display("FAIL midrst_next_data: got %h want 11", wd_q[0]); else pass_cnt++;
  endtask

`ifdef SPI_REGIF_BURST_EN
  task automatic test_burst_write();
    logic [15:0] rx;
    clear_log();
    cs_begin();
    spi_bits(16'h00FF, 8, rx);
    spi_bits(16'h0011, 8, rx);
    spi_bits(16'h0022, 8, rx);
    cs_end();
    chk_cnt++; if (wa_q.size() !== 2) $display("FAIL bw_count: got %0d want 2", wa_q.size()); else pass_cnt++;
    chk_cnt++; if (wa_q[0] !== 7'h7F) $display("FAIL bw_addr0: got %h want 7f", wa_q[0]);    else pass_cnt++;
    chk_cnt++; if (wd_q[0] !== 8'h11) $display("FAIL bw_data0: got %h want 11", wd_q[0]);    else pass_cnt++;
    chk_cnt++; if (wa_q[1] !== 7'h00) $display("FAIL bw_addr1: got %h want 00", wa_q[1]);    else pass_cnt++;
    chk_cnt++; if (wd_q[1] !== 8'h22) $display("FAIL bw_data1: got %h want 22", wd_q[1]);    else pass_cnt++;
  endtask

  task automatic test_burst_read();
    logic [15:0] rx;
    clear_log();
    cs_begin();
    spi_bits(16'h0003, 8, rx);
    spi_bits(16'h0000, 16, rx);
    cs_end();
    chk_cnt++; if (rx !== 16'h4344)   $display("FAIL br_miso: got %h want 4344", rx);          else pass_cnt++;
    chk_cnt++; if (ra_q.size() < 2)   $display("FAIL br_re_count: got %0d want >=2", ra_q.size()); else pass_cnt++;
    chk_cnt++; if (ra_q[0] !== 7'h03) $display("FAIL br_re_addr0: got %h want 03", ra_q[0]);  else pass_cnt++;
    chk_cnt++; if (ra_q[1] !== 7'h04) $display("FAIL br_re_addr1: got %h want 04", ra_q[1]);  else pass_cnt++;
    chk_cnt++; if (wa_q.size() !== 0) $display("FAIL br_we_count: got %0d want 0", wa_q.size()); else pass_cnt++;
  endtask
`else
  task automatic test_single_word_only();
    logic [15:0] rx;
    clear_log();
    cs_begin();
    spi_bits(16'h0084, 8, rx);
    spi_bits(16'h0001, 8, rx);
    spi_bits(16'h0002, 8, rx);
    cs_end();
    chk_cnt++; if (wa_q.size() !== 1) $display("FAIL nb_count: got %0d want 1", wa_q.size()); else pass_cnt++;
    chk_cnt++; if (wa_q[0] !== 7'h04) $display("FAIL nb_addr: got %h want 04", wa_q[0]);     else pass_cnt++;
    chk_cnt++; if (wd_q[0] !== 8'h01) $display("FAIL nb_data: got %h want 01", wd_q[0]);     else pass_cnt++;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    sclk  = 1'b0;
    cs    = 1'b1;
    mosi  = 1'b0;
    clks(5);
    test_reset();
    rst_n = 1'b1;
    clks(10);
    test_single_write();
    test_single_read();
    test_abort();
    test_reset_midframe();
`ifdef SPI_REGIF_BURST_EN
    test_burst_write();
    test_burst_read();
`else
    test_single_word_only();
`endif
    chk_cnt++; if (both_cnt !== 0) $display("FAIL we_re_overlap: got %0d want 0", both_cnt); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
